// File: rtl/asyn_pipe_pkg.sv
// Shared types and helpers for the stall pipeline entry arbiter.
package asyn_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DROP,
    DONE
  } arb_state_t;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned MAX_REQ     = 8;

  // Round-robin pick: first set bit of req at or above ptr, wrapping modulo n.
  function automatic logic [2:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input int unsigned        n
  );
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        idx = (32'(ptr) + i) % n;
        if (!found && req[idx]) begin
          win   = 3'(idx);
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/stall_entry_arbiter_sync.sv
// Multi-bit flop-chain synchronizer for asynchronous handshake wires.
module sync_2ff
  import asyn_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;

  // Shift the raw input through the synchronizer stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/stall_entry_arbiter.sv
// Round-robin arbiter sharing the stall pipeline input channel between
// N_REQ 4-phase producers; all handshake inputs are synchronized first.
module stall_entry_arbiter
  import asyn_pipe_pkg::*;
#(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_in,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  output logic [N_REQ-1:0]        ack_out,
  output logic                    req_out,
  output logic [DATA_W-1:0]       data_out,
  input  logic                    ack_in,
  input  logic                    hold,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  arb_state_t         state;
  logic [N_REQ-1:0]   sreq;
  logic               sack;
  logic [2:0]         ptr;
  logic [2:0]         owner;
  logic [MAX_REQ-1:0] sreq_pad;
  logic [2:0]         win;
  logic [N_REQ-1:0]   win_onehot;
  logic [DATA_W-1:0]  win_data;

  sync_2ff #(.WIDTH(N_REQ)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .d   (req_in),
    .q   (sreq)
  );

  sync_2ff #(.WIDTH(1)) u_sync_ack (
    .clk (clk),
    .rst (rst),
    .d   (ack_in),
    .q   (sack)
  );

  // Select the round-robin winner and its one-hot grant and data word.
  always_comb begin
    sreq_pad             = '0;
    sreq_pad[N_REQ-1:0]  = sreq;
    win                  = rr_pick(sreq_pad, ptr, N_REQ);
    win_onehot           = '0;
    win_data             = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (32'(win) == i) begin
        win_onehot[i] = 1'b1;
        win_data      = data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Handshake FSM with registered outputs, rotation pointer and data latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      grant    <= '0;
      ack_out  <= '0;
      req_out  <= 1'b0;
      busy     <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hold && (sreq != '0)) begin
            state    <= SEND;
            owner    <= win;
            grant    <= win_onehot;
            data_out <= win_data;
            req_out  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SEND: begin
          if (sack) begin
            state   <= DROP;
            req_out <= 1'b0;
          end
        end
        DROP: begin
          if (!sack) begin
            state   <= DONE;
            ack_out <= grant;
          end
        end
        DONE: begin
          // Owner's request is tested through the grant mask, so an early
          // drop during SEND/DROP simply lets DONE exit on its first cycle.
          if ((sreq & grant) == '0) begin
            state   <= IDLE;
            ack_out <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            ptr     <= (owner == 3'(N_REQ - 1)) ? 3'd0 : owner + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stall_entry_arbiter.sv
// Scoreboard bench for stall_entry_arbiter: producers, pipeline partner,
// directed scenarios and a grant/data/ack monitor.
module tb_stall_entry_arbiter;

  localparam int N = 3;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_in = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   ack_out;
  logic           req_out;
  logic [W-1:0]   data_out;
  logic           ack_in = 1'b0;
  logic           hold = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_grant_q[$];
  logic [W-1:0] exp_data_q[$];
  logic [N-1:0] cur_grant = '0;

  int           pending[N] = '{0, 0, 0};
  logic [W-1:0] dval[N]    = '{8'h3C, 8'hA5, 8'h5A};
  int           ack_delay  = 1;
  int           ack_hold   = 0;

  stall_entry_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .data_in  (data_in),
    .ack_out  (ack_out),
    .req_out  (req_out),
    .data_out (data_out),
    .ack_in   (ack_in),
    .hold     (hold),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [N-1:0] g, input logic [W-1:0] d);
    exp_grant_q.push_back(g);
    exp_data_q.push_back(d);
  endtask

  task automatic wait_req_out(input logic v, input int budget, input string name);
    int n = 0;
    while (req_out !== v && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(req_out), 32'(v));
  endtask

  task automatic wait_ack(input int idx, input logic v, input int budget, input string name);
    int n = 0;
    while (ack_out[idx] !== v && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(ack_out[idx]), 32'(v));
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n = 0;
    while (!(busy == 1'b0 && req_in == '0 && ack_in == 1'b0 &&
             pending[0] == 0 && pending[1] == 0 && pending[2] == 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_busy"}, 32'(busy), 32'(1'b0));
    check({name, "_grant"}, 32'(grant), 32'(0));
  endtask

  // Producers: raise a queued request with its data, drop it on ack.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req_in[i] && ack_out[i]) begin
          req_in[i] = 1'b0;
        end else if (!req_in[i] && !ack_out[i] && pending[i] > 0) begin
          data_in[i*W +: W] = dval[i];
          req_in[i] = 1'b1;
          pending[i] = pending[i] - 1;
        end
      end
    end
  end

  // Pipeline entry partner: ack after req_out rises, release after it falls.
  initial begin
    forever begin
      @(posedge req_out);
      repeat (ack_delay) @(negedge clk);
      ack_in = 1'b1;
      @(negedge req_out);
      repeat (ack_hold) @(negedge clk);
      @(negedge clk);
      ack_in = 1'b0;
    end
  end

  // Monitor: each new grant pops the scoreboard; ack_out must match owner.
  initial begin
    logic [N-1:0] pg;
    logic [N-1:0] pa;
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    pg = '0;
    pa = '0;
    forever begin
      @(posedge clk); #1;
      if (grant != '0 && pg == '0) begin
        if (exp_grant_q.size() == 0) begin
          check("unexpected_grant", 32'(grant), 32'(0));
        end else begin
          eg = exp_grant_q.pop_front();
          ed = exp_data_q.pop_front();
          check("grant", 32'(grant), 32'(eg));
          check("data_out", 32'(data_out), 32'(ed));
          cur_grant = eg;
        end
      end
      if (ack_out != '0 && pa == '0) begin
        check("ack_out", 32'(ack_out), 32'(cur_grant));
      end
      pg = grant;
      pa = ack_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_out", 32'(req_out), 32'(0));
    check("rst_ack_out", 32'(ack_out), 32'(0));
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_data_out", 32'(data_out), 32'(0));
    rst = 1'b0;

    // Single transfer from producer 1 with latency check
    @(negedge clk);
    push(3'b010, 8'hA5);
    pending[1] = 1;
    wait (req_in[1]);
    @(posedge clk); #1;
    check("t1_lat_edge0", 32'(req_out), 32'(0));
    @(posedge clk); #1;
    check("t1_lat_edge1", 32'(req_out), 32'(0));
    @(posedge clk); #1;
    check("t1_lat_edge2", 32'(req_out), 32'(1));
    wait_quiet(60, "t1_end");

    // All three request together: ptr=2 after producer 1, so order 2,0,1
    @(negedge clk);
    push(3'b100, 8'h5A);
    push(3'b001, 8'h3C);
    push(3'b010, 8'hA5);
    pending[0] = 1; pending[1] = 1; pending[2] = 1;
    wait_quiet(200, "ptr_end");

    // Hold blocks a new grant
    @(negedge clk);
    hold = 1'b1;
    push(3'b001, 8'h3C);
    pending[0] = 1;
    repeat (20) begin
      @(posedge clk); #1;
      check("hold_busy", 32'(busy), 32'(0));
      check("hold_req_out", 32'(req_out), 32'(0));
    end
    @(negedge clk);
    hold = 1'b0;
    wait_req_out(1'b1, 2, "hold_release");
    wait_quiet(60, "hold_end");

    // Hold asserted during SEND: transfer completes, no further grant
    @(negedge clk);
    push(3'b010, 8'hA5);
    push(3'b100, 8'h5A);
    pending[1] = 1;
    wait_req_out(1'b1, 10, "mid_send");
    hold = 1'b1;
    pending[2] = 1;
    wait_ack(1, 1'b1, 20, "mid_ack_rise");
    wait_ack(1, 1'b0, 20, "mid_ack_fall");
    repeat (20) begin
      @(posedge clk); #1;
      check("mid_hold_grant", 32'(grant), 32'(0));
      check("mid_hold_busy", 32'(busy), 32'(0));
    end
    @(negedge clk);
    hold = 1'b0;
    wait_quiet(60, "mid_end");

    // Slow partner keeps ack_in high for 50 cycles in DROP
    @(negedge clk);
    ack_hold = 50;
    push(3'b001, 8'h3C);
    pending[0] = 1;
    wait_req_out(1'b1, 10, "slow_send");
    wait_req_out(1'b0, 20, "slow_drop");
    n = 0;
    while (ack_in && n < 60) begin
      check("slow_req_out", 32'(req_out), 32'(0));
      check("slow_data", 32'(data_out), 32'(8'h3C));
      check("slow_busy", 32'(busy), 32'(1));
      @(posedge clk); #1;
      n++;
    end
    check("slow_bound", 32'(n < 60), 32'(1));
    ack_hold = 0;
    wait_quiet(60, "slow_end");

    // Reset asserted in DROP while producer 2 requests
    @(negedge clk);
    push(3'b100, 8'h5A);
    pending[2] = 1;
    wait_req_out(1'b1, 10, "rst_send");
    wait_req_out(1'b0, 20, "rst_drop");
    rst = 1'b1;
    #1;
    check("mid_rst_req_out", 32'(req_out), 32'(0));
    check("mid_rst_ack_out", 32'(ack_out), 32'(0));
    check("mid_rst_grant", 32'(grant), 32'(0));
    check("mid_rst_data", 32'(data_out), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    push(3'b100, 8'h5A);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_quiet(80, "rst_end");

    // Fairness: ptr=0, all three requesting and re-raising twice each
    @(negedge clk);
    push(3'b001, 8'h3C);
    push(3'b010, 8'hA5);
    push(3'b100, 8'h5A);
    push(3'b001, 8'h3C);
    push(3'b010, 8'hA5);
    push(3'b100, 8'h5A);
    pending[0] = 2; pending[1] = 2; pending[2] = 2;
    wait_quiet(400, "rr_end");

    check("scoreboard_empty", 32'(exp_grant_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
